// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data bus.
// Data wins arbitration; a just-served side sits out one cycle so both alternate.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iIReq,
    input  logic [31:0] iIAddr,
    output logic [31:0] oIRData,
    output logic        oIValid,
    input  logic        iDReq,
    input  logic        iDWrite,
    input  logic [3:0]  iDByteEnable,
    input  logic [31:0] iDAddr,
    input  logic [31:0] iDWData,
    output logic [31:0] oDRData,
    output logic        oDValid,
    output logic        oMReadEnable,
    output logic        oMWriteEnable,
    output logic [3:0]  oMByteEnable,
    output logic [31:0] oMAddress,
    output logic [31:0] oMWriteData,
    input  logic [31:0] iMReadData,
    input  logic        iMReady,
    output logic [1:0]  oGrant,
    output logic        oTimeout,
    output logic [31:0] mStallCycles
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS_I = 2'd1,
        ACCESS_D = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        wr;
    logic [7:0]  wait_cnt;
    logic        d_elig;
    logic        i_elig;
    logic        stall_evt;
    logic        in_access;
    logic        give_up;

    assign d_elig    = iDReq & ~oDValid;
    assign i_elig    = iIReq & ~oIValid;
    assign stall_evt = (iIReq & ~oIValid) | (iDReq & ~oDValid);
    assign in_access = (state != IDLE);
    assign give_up   = ~iMReady & (wait_cnt == WAIT_LAST);

    assign oGrant        = {state == ACCESS_D, state == ACCESS_I};
    assign oMReadEnable  = (state == ACCESS_I) | ((state == ACCESS_D) & ~wr);
    assign oMWriteEnable = (state == ACCESS_D) & wr;
    assign oMByteEnable  = in_access ? be : 4'b0000;
    assign oMAddress     = in_access ? addr : 32'd0;
    assign oMWriteData   = (state == ACCESS_D) ? wdata : 32'd0;

    // Arbitration, access sequencing, completion pulses and stall counting
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state        <= IDLE;
            addr         <= 32'd0;
            wdata        <= 32'd0;
            be           <= 4'b0000;
            wr           <= 1'b0;
            wait_cnt     <= 8'd0;
            oIRData      <= 32'd0;
            oIValid      <= 1'b0;
            oDRData      <= 32'd0;
            oDValid      <= 1'b0;
            oTimeout     <= 1'b0;
            mStallCycles <= 32'd0;
        end else begin
            oIValid <= 1'b0;
            oDValid <= 1'b0;
            if (stall_evt)
                mStallCycles <= mStallCycles + 32'd1;
            unique case (state)
                IDLE: begin
                    wait_cnt <= 8'd0;
                    if (d_elig) begin
                        state <= ACCESS_D;
                        addr  <= iDAddr;
                        wr    <= iDWrite;
                        be    <= iDByteEnable;
                        wdata <= iDWData;
                    end else if (i_elig) begin
                        state <= ACCESS_I;
                        addr  <= iIAddr;
                        wr    <= 1'b0;
                        be    <= 4'b1111;
                        wdata <= 32'd0;
                    end
                end
                ACCESS_I: begin
                    if (iMReady || give_up) begin
                        oIRData  <= iMReady ? iMReadData : 32'd0;
                        oIValid  <= 1'b1;
                        wait_cnt <= 8'd0;
                        state    <= IDLE;
                        if (!iMReady)
                            oTimeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ACCESS_D: begin
                    if (iMReady || give_up) begin
                        oDRData  <= (iMReady && !wr) ? iMReadData : 32'd0;
                        oDValid  <= 1'b1;
                        wait_cnt <= 8'd0;
                        state    <= IDLE;
                        if (!iMReady)
                            oTimeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

    localparam int TOUT = 8;

    logic        clk;
    logic        rst_n;
    logic        iIReq;
    logic [31:0] iIAddr;
    logic [31:0] oIRData;
    logic        oIValid;
    logic        iDReq;
    logic        iDWrite;
    logic [3:0]  iDByteEnable;
    logic [31:0] iDAddr;
    logic [31:0] iDWData;
    logic [31:0] oDRData;
    logic        oDValid;
    logic        oMReadEnable;
    logic        oMWriteEnable;
    logic [3:0]  oMByteEnable;
    logic [31:0] oMAddress;
    logic [31:0] oMWriteData;
    logic [31:0] iMReadData;
    logic        iMReady;
    logic [1:0]  oGrant;
    logic        oTimeout;
    logic [31:0] mStallCycles;

    int errors = 0;
    int checks = 0;
    logic cmp_en = 1'b0;

    mem_port_arbiter #(.TIMEOUT(TOUT)) dut (
        .iCLK(clk),
        .iRST(rst_n),
        .iIReq(iIReq),
        .iIAddr(iIAddr),
        .oIRData(oIRData),
        .oIValid(oIValid),
        .iDReq(iDReq),
        .iDWrite(iDWrite),
        .iDByteEnable(iDByteEnable),
        .iDAddr(iDAddr),
        .iDWData(iDWData),
        .oDRData(oDRData),
        .oDValid(oDValid),
        .oMReadEnable(oMReadEnable),
        .oMWriteEnable(oMWriteEnable),
        .oMByteEnable(oMByteEnable),
        .oMAddress(oMAddress),
        .oMWriteData(oMWriteData),
        .iMReadData(iMReadData),
        .iMReady(iMReady),
        .oGrant(oGrant),
        .oTimeout(oTimeout),
        .mStallCycles(mStallCycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the port (0 none, 1 instr, 2 data), how long it has
    // waited, the captured request, and the values the requesters should see.
    typedef struct packed {
        int          owner;
        int          waited;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        wr;
        logic [31:0] irdata;
        logic [31:0] drdata;
        logic        iv;
        logic        dv;
        logic        to;
        logic [31:0] stall;
    } model_t;

    model_t m;

    function automatic model_t next_model(input model_t s);
        model_t n;
        logic [31:0] data;
        n = s;
        n.iv = 1'b0;
        n.dv = 1'b0;
        if ((iIReq && !s.iv) || (iDReq && !s.dv))
            n.stall = s.stall + 32'd1;
        if (s.owner == 0) begin
            n.waited = 0;
            if (iDReq && !s.dv) begin
                n.owner = 2;
                n.addr  = iDAddr;
                n.wr    = iDWrite;
                n.be    = iDByteEnable;
                n.wdata = iDWData;
            end else if (iIReq && !s.iv) begin
                n.owner = 1;
                n.addr  = iIAddr;
                n.wr    = 1'b0;
                n.be    = 4'hF;
                n.wdata = 32'd0;
            end
        end else if (iMReady || (s.waited + 1 == TOUT)) begin
            data = iMReady ? iMReadData : 32'd0;
            if (s.owner == 2 && s.wr)
                data = 32'd0;
            if (!iMReady)
                n.to = 1'b1;
            if (s.owner == 1) begin
                n.irdata = data;
                n.iv     = 1'b1;
            end else begin
                n.drdata = data;
                n.dv     = 1'b1;
            end
            n.owner  = 0;
            n.waited = 0;
        end else begin
            n.waited = s.waited + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            m <= '0;
        else
            m <= next_model(m);
    end

    // Compare every DUT output with the model on each falling edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("grant", {30'd0, oGrant},
                (m.owner == 2) ? 32'd2 : (m.owner == 1) ? 32'd1 : 32'd0);
            chk("mre", {31'd0, oMReadEnable},
                {31'd0, (m.owner == 1) || (m.owner == 2 && !m.wr)});
            chk("mwe", {31'd0, oMWriteEnable},
                {31'd0, (m.owner == 2) && m.wr});
            chk("mbe", {28'd0, oMByteEnable},
                (m.owner != 0) ? {28'd0, m.be} : 32'd0);
            chk("maddr", oMAddress, (m.owner != 0) ? m.addr : 32'd0);
            chk("mwdata", oMWriteData, (m.owner == 2) ? m.wdata : 32'd0);
            chk("ivalid", {31'd0, oIValid}, {31'd0, m.iv});
            chk("dvalid", {31'd0, oDValid}, {31'd0, m.dv});
            chk("irdata", oIRData, m.irdata);
            chk("drdata", oDRData, m.drdata);
            chk("timeout", {31'd0, oTimeout}, {31'd0, m.to});
            chk("stall", mStallCycles, m.stall);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        iIReq        = 1'b0;
        iIAddr       = 32'd0;
        iDReq        = 1'b0;
        iDWrite      = 1'b0;
        iDByteEnable = 4'h0;
        iDAddr       = 32'd0;
        iDWData      = 32'd0;
        iMReadData   = 32'd0;
        iMReady      = 1'b0;
        cmp_en       = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_grant", {30'd0, oGrant}, 32'd0);
        chk("rst_valids", {30'd0, oIValid, oDValid}, 32'd0);
        chk("rst_strobes", {26'd0, oMReadEnable, oMWriteEnable, oMByteEnable}, 32'd0);
        chk("rst_timeout", {31'd0, oTimeout}, 32'd0);
        chk("rst_stall", mStallCycles, 32'd0);
        rst_n = 1'b1;
        step();

        // Instruction read, zero wait
        iIReq      = 1'b1;
        iIAddr     = 32'h0040_0000;
        iMReady    = 1'b1;
        iMReadData = 32'h0000_0013;
        step();
        @(negedge clk);
        chk("t1_mre", {31'd0, oMReadEnable}, 32'd1);
        chk("t1_maddr", oMAddress, 32'h0040_0000);
        chk("t1_grant", {30'd0, oGrant}, 32'd1);
        step();
        @(negedge clk);
        chk("t1_ivalid", {31'd0, oIValid}, 32'd1);
        chk("t1_irdata", oIRData, 32'h0000_0013);
        iIReq = 1'b0;
        repeat (2) step();

        // Both request and hold: D, I, D
        iIReq        = 1'b1;
        iIAddr       = 32'h0040_0004;
        iDReq        = 1'b1;
        iDWrite      = 1'b0;
        iDAddr       = 32'h1001_0000;
        iDByteEnable = 4'hF;
        iMReady      = 1'b1;
        iMReadData   = 32'h1111_1111;
        step();
        @(negedge clk);
        chk("t2_grant_c1", {30'd0, oGrant}, 32'd2);
        step();
        @(negedge clk);
        chk("t2_dvalid_c2", {31'd0, oDValid}, 32'd1);
        chk("t2_drdata_c2", oDRData, 32'h1111_1111);
        step();
        @(negedge clk);
        chk("t2_grant_c3", {30'd0, oGrant}, 32'd1);
        step();
        @(negedge clk);
        chk("t2_ivalid_c4", {31'd0, oIValid}, 32'd1);
        iIReq = 1'b0;
        step();
        @(negedge clk);
        chk("t2_grant_c5", {30'd0, oGrant}, 32'd2);
        iDReq = 1'b0;
        repeat (3) step();

        // Data write with three wait states; inputs change after grant
        iDReq        = 1'b1;
        iDWrite      = 1'b1;
        iDByteEnable = 4'b0011;
        iDWData      = 32'hDEAD_BEEF;
        iDAddr       = 32'h1001_0004;
        iMReady      = 1'b0;
        iMReadData   = 32'h5555_AAAA;
        for (int c = 1; c <= 4; c++) begin
            step();
            iMReady = (c == 4);
            if (c == 1) begin
                iDAddr       = 32'hFFFF_0000;
                iDWData      = 32'h0;
                iDByteEnable = 4'hF;
            end
            @(negedge clk);
            chk("t3_mwe", {31'd0, oMWriteEnable}, 32'd1);
            chk("t3_mre", {31'd0, oMReadEnable}, 32'd0);
            chk("t3_maddr", oMAddress, 32'h1001_0004);
            chk("t3_mbe", {28'd0, oMByteEnable}, 32'h3);
            chk("t3_mwdata", oMWriteData, 32'hDEAD_BEEF);
        end
        step();
        @(negedge clk);
        chk("t3_dvalid", {31'd0, oDValid}, 32'd1);
        chk("t3_drdata", oDRData, 32'd0);
        iDReq   = 1'b0;
        iDWrite = 1'b0;
        repeat (2) step();

        // Timeout on a data read
        iDReq        = 1'b1;
        iDWrite      = 1'b0;
        iDAddr       = 32'h1001_0008;
        iDByteEnable = 4'hF;
        iMReady      = 1'b0;
        iMReadData   = 32'hAAAA_5555;
        for (int c = 1; c <= 8; c++) begin
            step();
            @(negedge clk);
            chk("t4_access", {30'd0, oGrant}, 32'd2);
            chk("t4_novalid", {31'd0, oDValid}, 32'd0);
        end
        step();
        @(negedge clk);
        chk("t4_dvalid", {31'd0, oDValid}, 32'd1);
        chk("t4_drdata", oDRData, 32'd0);
        chk("t4_timeout", {31'd0, oTimeout}, 32'd1);
        iDReq = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("t4_timeout_sticky", {31'd0, oTimeout}, 32'd1);
        step();

        // Reset during the second access cycle of a data read
        iDReq   = 1'b1;
        iDAddr  = 32'h1001_000C;
        iMReady = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_grant", {30'd0, oGrant}, 32'd0);
        chk("t5_strobes", {26'd0, oMReadEnable, oMWriteEnable, oMByteEnable}, 32'd0);
        chk("t5_maddr", oMAddress, 32'd0);
        chk("t5_rdata", oDRData | oIRData, 32'd0);
        chk("t5_timeout", {31'd0, oTimeout}, 32'd0);
        chk("t5_stall", mStallCycles, 32'd0);
        iDReq = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge clk);
            chk("t5_post_valid", {30'd0, oIValid, oDValid}, 32'd0);
            chk("t5_post_grant", {30'd0, oGrant}, 32'd0);
        end
        step();

        // Stall counter: instruction read with two wait states
        iIReq      = 1'b1;
        iIAddr     = 32'h0040_0010;
        iMReady    = 1'b0;
        iMReadData = 32'h0000_0093;
        for (int c = 1; c <= 3; c++) begin
            step();
            iMReady = (c == 3);
        end
        step();
        @(negedge clk);
        chk("t6_ivalid", {31'd0, oIValid}, 32'd1);
        chk("t6_irdata", oIRData, 32'h0000_0093);
        chk("t6_stall", mStallCycles, 32'd4);
        iIReq   = 1'b0;
        iMReady = 1'b0;
        step();
        @(negedge clk);
        chk("t6_stall_hold", mStallCycles, 32'd4);
        repeat (2) step();

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
